// File: rtl/fsgn_issue_if.sv
// Handshake bundle for the FP sign-injection issue stage: decode side, fsgnj unit side and
// writeback side. The slave modport is the issue stage; the master modport is its environment.
interface fsgn_issue_if #(
  parameter int unsigned RDW = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_funct3;
  logic [RDW-1:0] in_rd;
  logic [31:0]    in_rs1;
  logic [31:0]    in_rs2;
  logic [31:0]    sgn_a;
  logic [31:0]    sgn_b;
  logic [31:0]    sgn_c;
  logic           out_valid;
  logic           out_ready;
  logic [RDW-1:0] out_rd;
  logic [31:0]    out_data;
  logic           out_illegal;

  modport master (
    output in_valid, in_funct3, in_rd, in_rs1, in_rs2, sgn_c, out_ready,
    input  in_ready, sgn_a, sgn_b, out_valid, out_rd, out_data, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_rd, in_rs1, in_rs2, sgn_c, out_ready,
    output in_ready, sgn_a, sgn_b, out_valid, out_rd, out_data, out_illegal
  );
endinterface

// File: rtl/fsgn_issue_stage.sv
// Op queue plus result register around a single fsgnj unit (c = {b[31], a[30:0]}).
// Operand b is pre-conditioned per funct3 so the same unit also serves fsgnjn and fsgnjx.
module fsgn_issue_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RDW   = 5
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  fsgn_issue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [2:0]     f3_mem  [DEPTH];
  logic [RDW-1:0] rd_mem  [DEPTH];
  logic [31:0]    rs1_mem [DEPTH];
  logic [31:0]    rs2_mem [DEPTH];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic           out_valid_q;
  logic [RDW-1:0] out_rd_q;
  logic [31:0]    out_data_q;
  logic           out_illegal_q;

  logic           empty, full, push, pop;
  logic [2:0]     head_f3;
  logic [31:0]    head_rs1, head_rs2;
  logic           head_illegal;
  logic [31:0]    sgn_a, sgn_b;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // in_ready depends only on registered count, never on out_ready.
  assign push = bus.in_valid && !full && !flush;
  assign pop  = !empty && (!out_valid_q || bus.out_ready) && !flush;

  assign head_f3  = f3_mem[rd_ptr_q];
  assign head_rs1 = rs1_mem[rd_ptr_q];
  assign head_rs2 = rs2_mem[rd_ptr_q];

  always_comb begin
    sgn_a        = '0;
    sgn_b        = '0;
    head_illegal = 1'b0;
    if (!empty) begin
      sgn_a = head_rs1;
      case (head_f3)
        3'b000:  sgn_b = head_rs2;
        3'b001:  sgn_b = {~head_rs2[31], head_rs2[30:0]};
        3'b010:  sgn_b = {head_rs1[31] ^ head_rs2[31], head_rs2[30:0]};
        default: begin
          // b = rs1 makes the unit pass rs1 through unchanged.
          sgn_b        = head_rs1;
          head_illegal = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f3_mem[wr_ptr_q]  <= bus.in_funct3;
      rd_mem[wr_ptr_q]  <= bus.in_rd;
      rs1_mem[wr_ptr_q] <= bus.in_rs1;
      rs2_mem[wr_ptr_q] <= bus.in_rs2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_data_q    <= '0;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_valid_q   <= 1'b1;
      out_rd_q      <= rd_mem[rd_ptr_q];
      out_data_q    <= bus.sgn_c;
      out_illegal_q <= head_illegal;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = !full;
  assign bus.sgn_a       = sgn_a;
  assign bus.sgn_b       = sgn_b;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_illegal = out_illegal_q;
endmodule

// File: tb/tb_fsgn_issue_stage.sv
// Directed and randomized checks of fsgn_issue_stage with a behavioural fsgnj unit attached.
module tb_fsgn_issue_stage;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RDW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected results, packed as {illegal, rd, data}.
  logic [RDW+32:0] exp_q[$];

  fsgn_issue_if #(.RDW(RDW)) bus ();

  fsgn_issue_stage #(.DEPTH(DEPTH), .RDW(RDW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  assign bus.sgn_c = {bus.sgn_b[31], bus.sgn_a[30:0]};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fsgn(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    case (f3)
      3'b000:  return {b[31], a[30:0]};
      3'b001:  return {~b[31], a[30:0]};
      3'b010:  return {a[31] ^ b[31], a[30:0]};
      default: return a;
    endcase
  endfunction

  function automatic logic [RDW+32:0] pack_exp(input logic [2:0] f3, input logic [RDW-1:0] rd,
                                               input logic [31:0] a, input logic [31:0] b);
    return {(f3 > 3'b010), rd, ref_fsgn(f3, a, b)};
  endfunction

  task automatic drive(input logic v, input logic [2:0] f3, input logic [RDW-1:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid  = v;
    bus.in_funct3 = f3;
    bus.in_rd     = rd;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
  endtask

  // One op through an idle stage; checks the two-cycle latency and the result fields.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [RDW-1:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input logic exp_ill);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(1'b1, f3, rd, a, b);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, '0);
    check({tag, "_valid_n1"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_sgn_a"}, 64'(bus.sgn_a), 64'(a));
    @(negedge clk);
    check({tag, "_valid_n2"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.out_data), 64'(exp_data));
    check({tag, "_rd"}, 64'(bus.out_rd), 64'(rd));
    check({tag, "_illegal"}, 64'(bus.out_illegal), 64'(exp_ill));
  endtask

  // Sample after the negedge; any consumed result is checked against the scoreboard.
  task automatic observe(input string tag, inout int got);
    logic [RDW+32:0] e;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check({tag, "_spurious"}, 64'(bus.out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_result"}, 64'({bus.out_illegal, bus.out_rd, bus.out_data}), 64'(e));
      end
      got++;
    end
  endtask

  initial begin
    int acc;
    int got;
    int k;
    int stale;
    logic [2:0]     f3;
    logic [RDW-1:0] rd;
    logic [31:0]    a, b;

    drive(1'b0, 3'b000, '0, '0, '0);
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_rd", 64'(bus.out_rd), 64'd0);
    check("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_sgn_ab", 64'({bus.sgn_a, bus.sgn_b}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("fsgnj",  3'b000, 5'd3, 32'h3F80_0000, 32'h8000_0000, 32'hBF80_0000, 1'b0);
    run_op("fsgnjn", 3'b001, 5'd4, 32'h3F80_0000, 32'h8000_0000, 32'h3F80_0000, 1'b0);
    run_op("fsgnjx", 3'b010, 5'd5, 32'hBF80_0000, 32'h8000_0000, 32'h3F80_0000, 1'b0);
    run_op("illegal", 3'b111, 5'd6, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op("fsgnjx_pos", 3'b010, 5'd7, 32'h4000_0000, 32'h8000_0001, 32'hC000_0000, 1'b0);

    // Backpressure: queue plus result register absorb DEPTH+1 ops, then in_ready drops.
    @(negedge clk);
    bus.out_ready = 1'b0;
    acc = 0;
    k = 0;
    for (int cyc = 0; cyc < DEPTH + 4; cyc++) begin
      @(negedge clk);
      f3 = 3'(k % 3);
      rd = RDW'(k + 10);
      a  = 32'h0040_0000 + 32'(k) + ((k % 2 == 1) ? 32'h8000_0000 : 32'h0);
      b  = (k % 4 < 2) ? 32'h8000_0000 : 32'h0000_0001;
      drive(1'b1, f3, rd, a, b);
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(pack_exp(f3, rd, a, b));
        acc++;
        k++;
      end
    end
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, '0);
    check("full_accepts", 64'(acc), 64'(DEPTH + 1));
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      observe("drain", got);
      @(negedge clk);
    end
    check("drain_count", 64'(got), 64'(DEPTH + 1));

    // Flush with one result held and three ops queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 3'b000, RDW'(20 + i), 32'h0000_1000 + 32'(i), 32'h8000_0000);
    end
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, '0);
    check("pre_flush_valid", 64'(bus.out_valid), 64'd1);
    check("pre_flush_in_ready", 64'(bus.in_ready), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_sgn_a", 64'(bus.sgn_a), 64'd0);
    bus.out_ready = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("flush_no_stale", 64'(stale), 64'd0);
    exp_q.delete();

    // Randomized stream against the reference model.
    got = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      drive(($urandom_range(0, 3) != 0), f3, RDW'($urandom), $urandom, $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      observe("rand", got);
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(pack_exp(bus.in_funct3, bus.in_rd, bus.in_rs1, bus.in_rs2));
    end
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, '0);
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      observe("rand_drain", got);
      @(negedge clk);
    end
    check("rand_leftover", 64'(exp_q.size()), 64'd0);
    check("rand_some_results", 64'(got > 1000), 64'd1);

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 3'b001, RDW'(i + 1), 32'h7F00_0000, 32'h0);
    end
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, '0);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_data", 64'(bus.out_data), 64'd0);
    check("arst_out_rd", 64'(bus.out_rd), 64'd0);
    check("arst_sgn_a", 64'(bus.sgn_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run_op("post_rst", 3'b000, 5'd9, 32'h0000_0005, 32'h8000_0000, 32'h8000_0005, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
